// File: rtl/ethernet_link_selector_pkg.sv
// Shared types for the Ethernet link selector: RX frame bus, link selection
// codes and selector FSM states.
package ethernet_link_selector_pkg;

  localparam int RX_DATA_W = 64;
  localparam int RX_BV_W   = 4;

  typedef enum logic [1:0] {
    LINK_NONE  = 2'd0,
    LINK_BASER = 2'd1,
    LINK_BASET = 2'd2
  } link_sel_t;

  typedef enum logic [1:0] {
    ST_NONE  = 2'd0,
    ST_BASER = 2'd1,
    ST_BASET = 2'd2,
    ST_DRAIN = 2'd3
  } sel_state_t;

  typedef struct packed {
    logic                 start;
    logic                 data_valid;
    logic [RX_BV_W-1:0]   bytes_valid;
    logic [RX_DATA_W-1:0] data;
    logic                 commit;
    logic                 drop;
  } eth_rx_bus_t;

  function automatic link_sel_t state_to_link(input sel_state_t s);
    case (s)
      ST_BASER: return LINK_BASER;
      ST_BASET: return LINK_BASET;
      default:  return LINK_NONE;
    endcase
  endfunction

  // A frame closes on commit/drop; a start+commit beat leaves the flag clear.
  function automatic logic in_frame_after(input logic in_frame, input eth_rx_bus_t bus);
    if (bus.commit || bus.drop) return 1'b0;
    if (bus.start) return 1'b1;
    return in_frame;
  endfunction

endpackage

// File: rtl/ethernet_link_selector_debouncer.sv
// Counts consecutive link-up cycles; the link becomes eligible once the count
// saturates at HOLDOFF_CYCLES and loses eligibility on any low cycle.
module ethernet_link_selector_debouncer #(
  parameter int unsigned HOLDOFF_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic link_up_i,
  output logic eligible_o
);

  localparam int unsigned CNT_W = (HOLDOFF_CYCLES == 0) ? 1 : $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLDOFF = CNT_W'(HOLDOFF_CYCLES);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (!link_up_i) begin
      count_d = '0;
    end else if (count_q != HOLDOFF) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign eligible_o = link_up_i && (count_q == HOLDOFF);

endmodule

// File: rtl/ethernet_link_selector.sv
// Selects the 10G (BASE-R) or 1G (BASE-T) RX frame stream, switching only at
// frame boundaries and truncating with a drop strobe when the active link dies.
module ethernet_link_selector
  import ethernet_link_selector_pkg::*;
#(
  parameter int unsigned HOLDOFF_CYCLES = 1000000,
  parameter int unsigned CTR_WIDTH      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 baser_link_up_i,
  input  logic                 baset_link_up_i,
  input  logic                 baser_rx_start_i,
  input  logic                 baser_rx_data_valid_i,
  input  logic [RX_BV_W-1:0]   baser_rx_bytes_valid_i,
  input  logic [RX_DATA_W-1:0] baser_rx_data_i,
  input  logic                 baser_rx_commit_i,
  input  logic                 baser_rx_drop_i,
  input  logic                 baset_rx_start_i,
  input  logic                 baset_rx_data_valid_i,
  input  logic [RX_BV_W-1:0]   baset_rx_bytes_valid_i,
  input  logic [RX_DATA_W-1:0] baset_rx_data_i,
  input  logic                 baset_rx_commit_i,
  input  logic                 baset_rx_drop_i,
  output logic                 muxed_rx_start_o,
  output logic                 muxed_rx_data_valid_o,
  output logic [RX_BV_W-1:0]   muxed_rx_bytes_valid_o,
  output logic [RX_DATA_W-1:0] muxed_rx_data_o,
  output logic                 muxed_rx_commit_o,
  output logic                 muxed_rx_drop_o,
  output logic [1:0]           active_link_o,
  output logic                 link_up_o,
  output logic [CTR_WIDTH-1:0] perf_switchovers_o,
  output logic [CTR_WIDTH-1:0] perf_truncated_o
);

  localparam int NUM_LINKS = 2;  // index 0 = BASE-R, index 1 = BASE-T

  logic [NUM_LINKS-1:0] link_up_vec;
  logic [NUM_LINKS-1:0] eligible;
  logic [NUM_LINKS-1:0] in_frame_q, in_frame_d;
  eth_rx_bus_t          src_bus [NUM_LINKS];

  assign link_up_vec = {baset_link_up_i, baser_link_up_i};

  assign src_bus[0] = '{start: baser_rx_start_i, data_valid: baser_rx_data_valid_i,
                        bytes_valid: baser_rx_bytes_valid_i, data: baser_rx_data_i,
                        commit: baser_rx_commit_i, drop: baser_rx_drop_i};
  assign src_bus[1] = '{start: baset_rx_start_i, data_valid: baset_rx_data_valid_i,
                        bytes_valid: baset_rx_bytes_valid_i, data: baset_rx_data_i,
                        commit: baset_rx_commit_i, drop: baset_rx_drop_i};

  generate
    for (genvar gi = 0; gi < NUM_LINKS; gi++) begin : g_link
      ethernet_link_selector_debouncer #(
        .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
      ) u_debouncer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .link_up_i  (link_up_vec[gi]),
        .eligible_o (eligible[gi])
      );
      // Tracked regardless of selection so a late switch knows to wait for a start.
      assign in_frame_d[gi] = in_frame_after(in_frame_q[gi], src_bus[gi]);
    end
  endgenerate

  sel_state_t           state_q, state_d, pref;
  logic                 suppress_q, suppress_d;
  logic                 out_open_q, out_open_d;
  logic                 pref_in_frame, cur_elig, trunc_inc, switch_inc;
  eth_rx_bus_t          out_q, out_d, cur_bus;
  logic [CTR_WIDTH-1:0] switch_cnt_q, trunc_cnt_q;

  always_comb begin
    pref = ST_NONE;
    if (eligible[0]) begin
      pref = ST_BASER;
    end else if (eligible[1]) begin
      pref = ST_BASET;
    end
  end

  assign pref_in_frame = (pref == ST_BASER) ? in_frame_d[0] :
                         (pref == ST_BASET) ? in_frame_d[1] : 1'b0;
  assign cur_bus  = (state_q == ST_BASET) ? src_bus[1]  : src_bus[0];
  assign cur_elig = (state_q == ST_BASET) ? eligible[1] : eligible[0];

  always_comb begin
    state_d    = state_q;
    suppress_d = suppress_q;
    out_open_d = out_open_q;
    out_d      = '0;
    trunc_inc  = 1'b0;
    case (state_q)
      ST_BASER, ST_BASET: begin
        if (!cur_elig) begin
          if (out_open_q) begin
            out_d.drop = 1'b1;
            out_open_d = 1'b0;
            trunc_inc  = 1'b1;
            state_d    = ST_DRAIN;
          end else begin
            state_d    = pref;
            suppress_d = pref_in_frame;
          end
        end else begin
          if (!suppress_q || cur_bus.start) begin
            out_d      = cur_bus;
            suppress_d = 1'b0;
            out_open_d = in_frame_after(out_open_q, cur_bus);
          end
          // Hand over only once the downstream frame is closed.
          if ((pref != state_q) && !out_open_d) begin
            state_d    = pref;
            suppress_d = pref_in_frame;
          end
        end
      end
      default: begin
        state_d    = pref;
        suppress_d = pref_in_frame;
        out_open_d = 1'b0;
      end
    endcase
  end

  assign switch_inc = (state_to_link(state_d) != state_to_link(state_q));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_NONE;
      suppress_q   <= 1'b0;
      out_open_q   <= 1'b0;
      out_q        <= '0;
      in_frame_q   <= '0;
      switch_cnt_q <= '0;
      trunc_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      suppress_q   <= suppress_d;
      out_open_q   <= out_open_d;
      out_q        <= out_d;
      in_frame_q   <= in_frame_d;
      switch_cnt_q <= switch_cnt_q + CTR_WIDTH'(switch_inc);
      trunc_cnt_q  <= trunc_cnt_q + CTR_WIDTH'(trunc_inc);
    end
  end

  assign muxed_rx_start_o       = out_q.start;
  assign muxed_rx_data_valid_o  = out_q.data_valid;
  assign muxed_rx_bytes_valid_o = out_q.bytes_valid;
  assign muxed_rx_data_o        = out_q.data;
  assign muxed_rx_commit_o      = out_q.commit;
  assign muxed_rx_drop_o        = out_q.drop;
  assign active_link_o          = state_to_link(state_q);
  assign link_up_o              = (state_to_link(state_q) != LINK_NONE);
  assign perf_switchovers_o     = switch_cnt_q;
  assign perf_truncated_o       = trunc_cnt_q;

endmodule
